// File: rtl/ram_wait_bank.sv
// rtl/ram_wait_bank.sv - byte-lane data RAM with programmable wait states and ready/rvalid/err handshake
module ram_wait_bank #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 16,
    parameter  int DEPTH  = 1024,
    parameter  int WAIT   = 0,
    localparam int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read,
    input  logic [NB-1:0]     write,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              ready,
    output logic              rvalid,
    output logic              err
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_CNT = 4'(WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic [NB-1:0]     write_q, write_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    // Completing request: live inputs when finishing on the accept edge, latched copy when finishing from BUSY
    logic [ADDR_W-1:0] c_addr;
    logic              c_read;
    logic [NB-1:0]     c_write;
    logic [DATA_W-1:0] c_din;
    logic [IDX_W-1:0]  c_idx;
    logic              c_in_range;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic              mem_we;
    logic              accept;
    logic              done;

    assign ready    = (state_q == IDLE);
    assign DATA_OUT = dout_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;

    // Select the request being completed and build the lane-merged word (write applied before read)
    always_comb begin
        c_addr  = addr;
        c_read  = read;
        c_write = write;
        c_din   = DATA_IN;
        if (state_q == BUSY) begin
            c_addr  = addr_q;
            c_read  = read_q;
            c_write = write_q;
            c_din   = din_q;
        end
        c_idx      = c_addr[IDX_W-1:0];
        c_in_range = ({1'b0, c_addr} < DEPTH_L);
        old_word   = mem[c_idx];
        merged     = old_word;
        for (int k = 0; k < NB; k++) begin
            if (c_write[k]) begin
                merged[8*k +: 8] = c_din[8*k +: 8];
            end
        end
    end

    // IDLE/BUSY sequencing, request latching and completion side effects
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        read_d   = read_q;
        write_d  = write_q;
        din_d    = din_q;
        dout_d   = dout_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        accept   = ready && (read || (|write));

        if (state_q == IDLE) begin
            if (accept) begin
                addr_d  = addr;
                read_d  = read;
                write_d = write;
                din_d   = DATA_IN;
                if (WAIT == 0) begin
                    done = 1'b1;
                end else begin
                    state_d = BUSY;
                    cnt_d   = WAIT_CNT;
                end
            end
        end else begin
            if (cnt_q == 4'd1) begin
                done    = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        if (done) begin
            if (c_in_range) begin
                mem_we = |c_write;
                if (c_read) begin
                    dout_d   = merged;
                    rvalid_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
                if (c_read) begin
                    dout_d   = '0;
                    rvalid_d = 1'b1;
                end
            end
        end
    end

    // Register update; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= '0;
            din_q    <= '0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            write_q  <= write_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Array write of the merged word; suppressed by reset so an aborted access leaves memory intact
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[c_idx] <= merged;
        end
    end

endmodule
